// File: rtl/seq_booth_mult_if.sv
// Operand/result bundle for seq_booth_mult.
// master: the operand source that requests a multiply and consumes the product.
// slave:  the multiplier itself.
interface seq_booth_mult_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a_in, b_in,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a_in, b_in,
        output busy, done, product
    );
endinterface

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier: IDLE -> CALC (WIDTH+1 steps) -> DONE -> IDLE.
// Operands are extended by one bit so signed and unsigned share one datapath.
// Build option EARLY_TERM_EN: a zero operand skips CALC and returns product 0 one clock
// after the start edge.
module seq_booth_mult #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             reset,
    seq_booth_mult_if.slave bus
);
    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LastStep = CW'(W1 - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic [W1-1:0]      r_mcand;
    logic [W1-1:0]      r_mplier;
    logic               r_qm1;
    logic [W1:0]        r_acc;
    logic [2*WIDTH-1:0] r_product;

    logic [W1-1:0]      w_a_ext;
    logic [W1-1:0]      w_b_ext;
    logic [W1:0]        w_mcand_ext;
    logic [W1:0]        w_sum;
    logic [W1:0]        w_acc_shift;
    logic [W1-1:0]      w_mplier_shift;
    logic               w_zero_op;

    // Operand extension and one Booth step (add/sub then arithmetic shift of {acc,Q,q-1}).
    always_comb begin
        w_a_ext     = {bus.signed_mode & bus.a_in[WIDTH-1], bus.a_in};
        w_b_ext     = {bus.signed_mode & bus.b_in[WIDTH-1], bus.b_in};
        // Extra acc bit lets -A of the most negative operand stay representable.
        w_mcand_ext = {r_mcand[W1-1], r_mcand};
        unique case ({r_mplier[0], r_qm1})
            2'b01:   w_sum = r_acc + w_mcand_ext;
            2'b10:   w_sum = r_acc - w_mcand_ext;
            default: w_sum = r_acc;
        endcase
        w_acc_shift    = {w_sum[W1], w_sum[W1:1]};
        w_mplier_shift = {w_sum[0], r_mplier[W1-1:1]};
    end

`ifdef EARLY_TERM_EN
    assign w_zero_op = (bus.a_in == '0) || (bus.b_in == '0);
`else
    assign w_zero_op = 1'b0;
`endif

    // Control FSM and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_count   <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_qm1     <= 1'b0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        if (w_zero_op) begin
                            r_state   <= StDone;
                            r_product <= '0;
                        end else begin
                            r_state  <= StCalc;
                            r_mcand  <= w_a_ext;
                            r_mplier <= w_b_ext;
                            r_qm1    <= 1'b0;
                            r_acc    <= '0;
                            r_count  <= '0;
                        end
                    end
                end
                StCalc: begin
                    r_acc    <= w_acc_shift;
                    r_mplier <= w_mplier_shift;
                    r_qm1    <= r_mplier[0];
                    r_count  <= r_count + CW'(1);
                    if (r_count == LastStep) begin
                        r_state   <= StDone;
                        r_product <= {w_acc_shift[WIDTH-2:0], w_mplier_shift};
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy    = (r_state == StCalc) || (r_state == StDone);
    assign bus.done    = (r_state == StDone);
    assign bus.product = r_product;

endmodule
